// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word bit masks, trace classes, record layout.
package cpu_pkg;
    localparam int STEP_MAX = 6;
    localparam int CTRL_W   = 17;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Control-word masks, one bit each, MSB first.
    localparam ctrl_t C_OUT_EN    = 17'h10000;
    localparam ctrl_t C_ALU_FLAGS = 17'h08000;
    localparam ctrl_t C_ALU_SUB   = 17'h04000;
    localparam ctrl_t C_ALU_OUT   = 17'h02000;
    localparam ctrl_t C_RAM_W     = 17'h01000;
    localparam ctrl_t C_RAM_R     = 17'h00800;
    localparam ctrl_t C_MAR_R     = 17'h00400;
    localparam ctrl_t C_I_W       = 17'h00200;
    localparam ctrl_t C_I_R       = 17'h00100;
    localparam ctrl_t C_B_W       = 17'h00080;
    localparam ctrl_t C_B_R       = 17'h00040;
    localparam ctrl_t C_A_W       = 17'h00020;
    localparam ctrl_t C_A_R       = 17'h00010;
    localparam ctrl_t C_PC_JUMP   = 17'h00008;
    localparam ctrl_t C_PC_INC    = 17'h00004;
    localparam ctrl_t C_PC_OUT    = 17'h00002;
    localparam ctrl_t C_CLK_HALT  = 17'h00001;

    // Fetch microstep is exactly PC onto the bus, latched by the MAR.
    localparam ctrl_t FETCH_SIG = C_PC_OUT | C_MAR_R;
    // Every control line that drives the shared bus.
    localparam ctrl_t BUS_DRIVERS = C_PC_OUT | C_A_W | C_B_W | C_I_W | C_RAM_W | C_ALU_OUT;

    typedef enum logic [3:0] {
        CLS_UNKNOWN = 4'h0,
        CLS_LOADA   = 4'h1,
        CLS_ADD     = 4'h2,
        CLS_SUB     = 4'h3,
        CLS_STOREA  = 4'h4,
        CLS_LOAD_IM = 4'h5,
        CLS_JUMP    = 4'h6,
        CLS_NOP     = 4'h9,
        CLS_OUT     = 4'hE,
        CLS_HALT    = 4'hF
    } trace_cls_e;

    typedef struct packed {
        trace_cls_e  cls;
        logic [3:0]  pc;
        logic [7:0]  opnd;
    } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word fall-through; rdata reads 0 when empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
    logic                      do_push, do_pop;

    // Pointer/storage next-state; a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/ctrl_trace_decoder.sv
// Passive monitor of the microcode control word: rebuilds each executed
// instruction into a 16-bit trace record and queues it for a consumer.
module ctrl_trace_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int STEP_MAX   = cpu_pkg::STEP_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] ctrl,
    input  logic [7:0]  bus,
    output logic [15:0] trace_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic        err_contention,
    output logic        err_sync,
    output logic        err_overflow,
    output logic [7:0]  drop_count,
    input  logic        clear_err
);
    import cpu_pkg::*;

    localparam int SW = $clog2(STEP_MAX + 1);
    localparam logic [SW-1:0] S_0    = '0;
    localparam logic [SW-1:0] S_2    = SW'(2);
    localparam logic [SW-1:0] S_3    = SW'(3);
    localparam logic [SW-1:0] S_4    = SW'(4);
    localparam logic [SW-1:0] S_LAST = SW'(STEP_MAX);

    function automatic trace_cls_e classify(ctrl_t s2, ctrl_t s3, ctrl_t s4);
        ctrl_t alu = C_ALU_OUT | C_ALU_FLAGS | C_A_R;
        if (s2 == (C_I_W | C_MAR_R)) begin
            if (s3 == (C_RAM_W | C_A_R))                           return CLS_LOADA;
            if (s3 == (C_RAM_W | C_B_R) && s4 == alu)              return CLS_ADD;
            if (s3 == (C_RAM_W | C_B_R) && s4 == (alu | C_ALU_SUB)) return CLS_SUB;
            if (s3 == (C_A_W | C_RAM_R))                           return CLS_STOREA;
            return CLS_UNKNOWN;
        end
        if (s2 == (C_I_W | C_A_R))      return CLS_LOAD_IM;
        if (s2 == (C_I_W | C_PC_JUMP))  return CLS_JUMP;
        if (s2 == '0)                   return CLS_NOP;
        if (s2 == (C_A_W | C_OUT_EN))   return CLS_OUT;
        return CLS_UNKNOWN;
    endfunction

    // Operand as it appears in the record: immediates are only the low nibble.
    function automatic logic [7:0] rec_opnd(trace_cls_e c, logic [7:0] o);
        case (c)
            CLS_STOREA, CLS_NOP:               return 8'h00;
            CLS_LOADA, CLS_LOAD_IM, CLS_JUMP:  return {4'h0, o[3:0]};
            default:                           return o;
        endcase
    endfunction

    logic [SW-1:0] step_q, step_d;
    logic [3:0]    pc_q, pc_d;
    logic [7:0]    opnd_q, opnd_d;
    ctrl_t         sig2_q, sig2_d, sig3_q, sig3_d, sig4_q, sig4_d;
    logic          cont_inst_q, cont_inst_d, halted_q, halted_d;
    logic          err_cont_q, err_cont_d, err_sync_q, err_sync_d, err_ovf_q, err_ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          fetch, cont_now, sync_set, push, pop, drop, fifo_empty, fifo_full;
    trace_cls_e    cls;
    trace_rec_t    push_rec;

    // Step tracking, captures, record assembly and error bookkeeping.
    always_comb begin
        fetch       = (ctrl == FETCH_SIG);
        cont_now    = $countones(ctrl & BUS_DRIVERS) > 1;
        step_d      = step_q;
        pc_d        = pc_q;
        opnd_d      = opnd_q;
        sig2_d      = sig2_q;
        sig3_d      = sig3_q;
        sig4_d      = sig4_q;
        cont_inst_d = cont_inst_q;
        halted_d    = halted_q;
        sync_set    = 1'b0;
        push        = 1'b0;
        push_rec    = '0;
        cls = (cont_inst_q || cont_now) ? CLS_UNKNOWN : classify(sig2_q, sig3_q, sig4_q);
        if (!halted_q) begin
            if (fetch) begin
                // A fetch anywhere but step 0 restarts the instruction; the partial one never reaches the push step.
                sync_set    = (step_q != S_0);
                pc_d        = bus[3:0];
                cont_inst_d = 1'b0;
                step_d      = SW'(1);
            end else if (step_q == S_0) begin
                sync_set = 1'b1;
            end else begin
                cont_inst_d = cont_inst_q | cont_now;
                step_d      = (step_q == S_LAST) ? S_0 : step_q + SW'(1);
                case (step_q)
                    S_2: begin
                        sig2_d = ctrl;
                        opnd_d = bus;
                        if ((ctrl & C_CLK_HALT) != '0) begin
                            push     = 1'b1;
                            push_rec = '{cls: CLS_HALT, pc: pc_q, opnd: 8'h00};
                            halted_d = 1'b1;
                            step_d   = step_q;
                        end
                    end
                    S_3: sig3_d = ctrl;
                    S_4: begin
                        sig4_d = ctrl;
                        if ((ctrl & C_ALU_OUT) != '0) opnd_d = bus;
                    end
                    default: ;
                endcase
                if (step_q == S_LAST) begin
                    push     = 1'b1;
                    push_rec = '{cls: cls, pc: pc_q, opnd: rec_opnd(cls, opnd_q)};
                end
            end
        end
        pop  = trace_ready && !fifo_empty;
        drop = push && fifo_full && !pop;
        // clear_err wins over any error raised in the same cycle.
        err_cont_d = clear_err ? 1'b0 : (err_cont_q | cont_now);
        err_sync_d = clear_err ? 1'b0 : (err_sync_q | sync_set);
        err_ovf_d  = clear_err ? 1'b0 : (err_ovf_q | drop);
        drop_d     = clear_err ? 8'h00 : ((drop && drop_q != 8'hFF) ? drop_q + 8'h01 : drop_q);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q      <= S_0;
            pc_q        <= '0;
            opnd_q      <= '0;
            sig2_q      <= '0;
            sig3_q      <= '0;
            sig4_q      <= '0;
            cont_inst_q <= 1'b0;
            halted_q    <= 1'b0;
            err_cont_q  <= 1'b0;
            err_sync_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            step_q      <= step_d;
            pc_q        <= pc_d;
            opnd_q      <= opnd_d;
            sig2_q      <= sig2_d;
            sig3_q      <= sig3_d;
            sig4_q      <= sig4_d;
            cont_inst_q <= cont_inst_d;
            halted_q    <= halted_d;
            err_cont_q  <= err_cont_d;
            err_sync_q  <= err_sync_d;
            err_ovf_q   <= err_ovf_d;
            drop_q      <= drop_d;
        end
    end

    trace_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_rec),
        .pop   (pop),
        .rdata (trace_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign trace_valid    = !fifo_empty;
    assign err_contention = err_cont_q;
    assign err_sync       = err_sync_q;
    assign err_overflow   = err_ovf_q;
    assign drop_count     = drop_q;
endmodule

// File: tb/tb_ctrl_trace_decoder.sv
// Directed bench for ctrl_trace_decoder: drives microstep sequences and
// checks trace records, error flags and FIFO behaviour.
module tb_ctrl_trace_decoder;
    import cpu_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    ctrl_t       ctrl = '0;
    logic [7:0]  bus = '0;
    logic [15:0] trace_data;
    logic        trace_valid;
    logic        trace_ready = 1'b1;
    logic        err_contention, err_sync, err_overflow;
    logic [7:0]  drop_count;
    logic        clear_err = 1'b0;

    int checks = 0;
    int errors = 0;

    ctrl_trace_decoder #(.FIFO_DEPTH(DEPTH), .STEP_MAX(6)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .bus(bus),
        .trace_data(trace_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .err_contention(err_contention), .err_sync(err_sync), .err_overflow(err_overflow),
        .drop_count(drop_count), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a posedge, are sampled on the next posedge.
    task automatic step(input ctrl_t c, input logic [7:0] b);
        ctrl = c;
        bus  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] pc, input ctrl_t c2, input logic [7:0] b2,
                         input ctrl_t c3, input ctrl_t c4, input logic [7:0] b4);
        step(FETCH_SIG, {4'h0, pc});
        step(C_RAM_W | C_I_R | C_PC_INC, 8'h00);
        step(c2, b2);
        step(c3, 8'h00);
        step(c4, b4);
        step('0, 8'h00);
        step('0, 8'h00);
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_errs"}, {13'h0, err_contention, err_sync, err_overflow}, 16'h0000);
    endtask

    localparam ctrl_t IWM  = C_I_W | C_MAR_R;
    localparam ctrl_t ALUC = C_ALU_OUT | C_ALU_FLAGS | C_A_R;

    initial begin
        int vcnt;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(trace_valid), 16'h0);
        chk("rst_data", trace_data, 16'h0000);
        chk_errs("rst");
        chk("rst_drop", 16'(drop_count), 16'h0);
        rst = 1'b1;

        // LOADA
        instr(4'h3, IWM, 8'h0E, C_RAM_W | C_A_R, '0, 8'h00);
        chk("loada_valid", 16'(trace_valid), 16'h1);
        chk("loada_rec", trace_data, 16'h130E);
        chk_errs("loada");

        // ADD / SUB with ALU result captured at step 4
        instr(4'h4, IWM, 8'h07, C_RAM_W | C_B_R, ALUC, 8'h2A);
        chk("add_rec", trace_data, 16'h242A);
        instr(4'h4, IWM, 8'h07, C_RAM_W | C_B_R, ALUC | C_ALU_SUB, 8'h05);
        chk("sub_rec", trace_data, 16'h3405);

        // Not-taken jump, then taken jump (upper bus nibble must be dropped)
        instr(4'h7, '0, 8'h55, '0, '0, 8'h00);
        chk("nop_rec", trace_data, 16'h9700);
        instr(4'h8, C_I_W | C_PC_JUMP, 8'hA2, '0, '0, 8'h00);
        chk("jump_rec", trace_data, 16'h6802);

        // LOAD_IM, OUT, STOREA
        instr(4'hB, C_I_W | C_A_R, 8'h57, '0, '0, 8'h00);
        chk("ldim_rec", trace_data, 16'h5B07);
        instr(4'h1, C_A_W | C_OUT_EN, 8'h99, '0, '0, 8'h00);
        chk("out_rec", trace_data, 16'hE199);
        instr(4'h2, IWM, 8'h0C, C_A_W | C_RAM_R, '0, 8'h00);
        chk("storea_rec", trace_data, 16'h4200);
        chk_errs("clean_seq");

        // Bus contention at step 2
        instr(4'h5, C_I_W | C_A_W, 8'h11, '0, '0, 8'h00);
        chk("cont_flag", 16'(err_contention), 16'h1);
        chk("cont_rec_cls_pc", {8'h00, trace_data[15:8]}, 16'h0005);
        // Idle step with clear_err: the same-cycle sync error must not survive the clear
        clear_err = 1'b1;
        step('0, 8'h00);
        clear_err = 1'b0;
        chk("clear_errs", {13'h0, err_contention, err_sync, err_overflow}, 16'h0000);
        chk("clear_popped", 16'(trace_valid), 16'h0);

        // Overflow: DEPTH+3 instructions with consumer stalled
        trace_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++)
            instr(4'(i), IWM, 8'(i), C_RAM_W | C_A_R, '0, 8'h00);
        chk("ovf_valid", 16'(trace_valid), 16'h1);
        chk("ovf_flag", 16'(err_overflow), 16'h1);
        chk("ovf_drops", 16'(drop_count), 16'd3);
        trace_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovf_order%0d", i), trace_data, 16'h1000 | 16'(i << 8) | 16'(i));
            step('0, 8'h00);
        end
        chk("ovf_drained", 16'(trace_valid), 16'h0);
        clear_err = 1'b1;
        step('0, 8'h00);
        clear_err = 1'b0;
        chk("ovf_cleared", {7'h0, err_overflow, drop_count}, 16'h0000);

        // Halt at step 2
        step(FETCH_SIG, 8'h0F);
        step(C_RAM_W | C_I_R | C_PC_INC, 8'h00);
        step(C_CLK_HALT, 8'h00);
        chk("halt_rec", trace_data, 16'hFF00);
        chk("halt_valid", 16'(trace_valid), 16'h1);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            case (i % 7)
                0: step(FETCH_SIG, 8'h01);
                2: step(IWM, 8'h0E);
                3: step(C_RAM_W | C_A_R, 8'h00);
                default: step('0, 8'h00);
            endcase
            if (trace_valid) vcnt++;
        end
        chk("halt_frozen", 16'(vcnt), 16'h0);

        // Asynchronous reset mid-run clears everything
        rst = 1'b0;
        #1;
        chk("rst2_state", {trace_valid, 4'h0, err_contention, err_sync, err_overflow, drop_count}, 16'h0000);
        chk("rst2_data", trace_data, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fetch signature inserted at step 4 -> resync, partial instruction discarded
        step(FETCH_SIG, 8'h06);
        step(C_RAM_W | C_I_R | C_PC_INC, 8'h00);
        step(IWM, 8'h0E);
        step(C_RAM_W | C_A_R, 8'h00);
        chk("pre_sync", 16'(err_sync), 16'h0);
        step(FETCH_SIG, 8'h09);
        chk("sync_flag", 16'(err_sync), 16'h1);
        step(C_RAM_W | C_I_R | C_PC_INC, 8'h00);
        step(IWM, 8'h0E);
        step(C_RAM_W | C_A_R, 8'h00);
        step('0, 8'h00);
        step('0, 8'h00);
        chk("sync_no_partial", 16'(trace_valid), 16'h0);
        step('0, 8'h00);
        chk("sync_rec", trace_data, 16'h190E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_trace_decoder.md
Name: ctrl_trace_decoder

Overview:
- Passive monitor on the CPU control word and the 8-bit bus; the decoding end of the microcode control sequencer.
- Samples the 17 control lines each step and reconstructs which instruction class executed, plus its PC and operand.
- Pushes one 16-bit trace record per instruction into an internal FIFO, read out through a valid/ready port.
- Flags bus contention, loss of step synchronisation and FIFO overflow. Used for debug and for bench scoreboarding of the CPU.

Parameters:
- FIFO_DEPTH, 8, trace FIFO entries; power of two, minimum 2.
- STEP_MAX, 6, last microstep index; matches the sequencer's 7-step cycle.

Ports:
- clk  in  1  system clock; the sequencer changes control on negedge, this block samples on posedge.
- rst  in  1  asynchronous, active-low reset.
- ctrl  in  17  control word, packed {out_en, alu_flags_in, alu_sub, alu_out, ram_write_to_bus, ram_read_from_bus, mar_read, i_write, i_read, b_write, b_read, a_write, a_read, pc_jump, pc_inc, pc_out, clk_halt}.
- bus  in  8  shared CPU data bus.
- trace_data  out  16  record {class[15:12], pc[11:8], operand[7:0]}.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts the head record when valid&ready at posedge.
- err_contention  out  1  sticky.
- err_sync  out  1  sticky.
- err_overflow  out  1  sticky.
- drop_count  out  8  records dropped on overflow; saturates at 255.
- clear_err  in  1  synchronous clear of the sticky flags and drop_count.

Behaviour:
- Reset (rst=0, async): step counter=0; FIFO empty; trace_valid=0; trace_data=0; all error flags 0; drop_count=0; capture registers 0; halted=0.
- Step counter:
  - Advances 0..STEP_MAX at each posedge, then wraps to 0.
  - Step 0 is the fetch signature: ctrl == pc_out|mar_read exactly.
  - Resync: if the fetch signature is seen at a step other than 0, set err_sync, discard the partial instruction (no record), and set the counter to 1 next cycle.
  - If step 0 is reached without the fetch signature, set err_sync and hold at 0 until the signature is seen.
- Captures:
  - Step 0: pc <= bus[3:0].
  - Step 2: sig2 <= ctrl; opnd <= bus.
  - Step 3: sig3 <= ctrl.
  - Step 4: sig4 <= ctrl; if ctrl.alu_out, opnd <= bus (ALU result).
- Classification (uses the CPU opcode encodings):
  - sig2 = i_write|mar_read with sig3 = ram_write|a_read -> 0x1 LOADA.
  - sig2 = i_write|mar_read with sig3 = ram_write|b_read and sig4 = alu_out|alu_flags|a_read -> 0x2 ADD; the same with alu_sub -> 0x3 SUB.
  - sig2 = i_write|mar_read with sig3 = a_write|ram_read -> 0x4 STOREA.
  - sig2 = i_write|a_read -> 0x5 LOAD_IM.
  - sig2 = i_write|pc_jump -> 0x6 JUMP-taken (covers JUMP, JUMPC and JUMPZ when taken).
  - sig2 = 0 -> 0x9 NOP/not-taken.
  - sig2 = a_write|out_en -> 0xE OUT.
  - Anything else -> 0x0 UNKNOWN.
  - opnd is forced to 0 for STOREA and NOP/not-taken. For LOADA, LOAD_IM and JUMP-taken, opnd is bus[3:0] zero-extended.
- Record push: at the posedge sampling step STEP_MAX, write {class, pc, opnd} into the FIFO.
- Halt:
  - ctrl.clk_halt at step 2 pushes {0xF, pc, 0x00} immediately and sets halted.
  - While halted, the step counter freezes and no further records are generated; only rst clears halted.
- Contention: more than one of {pc_out, a_write, b_write, i_write, ram_write, alu_out} high in any sampled step sets err_contention and forces the current record's class to 0x0.
- FIFO:
  - First-word fall-through: trace_data is the head entry, 0 when empty.
  - Simultaneous push and pop when full: both succeed, no drop.
  - Push when full without a pop: record dropped, err_overflow set, drop_count incremented (saturating).
- clear_err has priority over a same-cycle error set: the flags read 0 after that edge and re-arm on the next cycle.
- Reset mid-instruction: the partial instruction is discarded and FIFO contents are lost.
- Latency: a record is visible on trace_valid one cycle after the step-STEP_MAX sample.

Decomposition:
- Package cpu_pkg:
  - Opcode/class constants.
  - 17-bit control-bit masks with fixed bit positions.
  - Trace record struct.
  - STEP_MAX.
- One sub-module, trace_fifo: parameterised sync FIFO with full/empty and first-word fall-through output.
- Classification is a function inside ctrl_trace_decoder.

Test Plan:
- Drive LOADA sequence, bus = pc 0x3 at step 0 and 0x0E at step 2 -> record 0x130E, err flags 0.
- Drive ADD sequence with pc 0x4 and bus 0x2A at step 4 -> record 0x242A. Same with alu_sub and bus 0x05 -> 0x3405.
- Drive JUMPZ not taken (sig2 = 0) at pc 0x7, then JUMP to 0x2 at pc 0x8 -> records 0x9700, then 0x6802.
- Drive step 2 with i_write|a_write -> err_contention=1, record class 0x0. Pulse clear_err -> flag 0.
- Hold trace_ready=0 for FIFO_DEPTH+3 instructions -> trace_valid=1, err_overflow=1, drop_count=3, first FIFO_DEPTH records intact and in order.
- Drive clk_halt at step 2, pc 0xF -> record 0xFF00; no further records for 20 cycles. Insert the fetch signature at step 4 in a separate run -> err_sync=1, no record for that partial instruction.
